trigger_capture_ctrl: RTL

Acquisition front-end of the scope, directly upstream of the measurements block. Streams ADC samples into the circular sample RAM and detects level/edge triggers with a pre-trigger window. On capture completion, publishes sample_start_address (first displayed sample), which the measurements stage registers as its sample start address.

---
 rtl/scope_pkg.sv | 26 ++
 rtl/trigger_detect.sv | 59 +++++
 rtl/trigger_capture_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared acquisition/measurement definitions: capture FSM states, trigger
// edge encodings and the default RAM geometry.
package scope_pkg;

    localparam int SCOPE_ADDR_WIDTH   = 15;
    localparam int SCOPE_SAMPLE_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFILL  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POSTFILL = 3'd3,
        ST_DONE     = 3'd4
    } cap_state_e;

    typedef enum logic {
        EDGE_RISING  = 1'b0,
        EDGE_FALLING = 1'b1
    } trig_edge_e;

    // States in which samples are accepted and written to the RAM.
    function automatic logic is_busy(input cap_state_e s);
        return (s == ST_PREFILL) || (s == ST_ARMED) || (s == ST_POSTFILL);
    endfunction

endpackage

// File: rtl/trigger_detect.sv
// Edge/level trigger detector: keeps the previous accepted sample, compares
// the current one against the threshold and runs the auto-trigger timeout.
module trigger_detect
    import scope_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SCOPE_SAMPLE_WIDTH,
    parameter int TIMEOUT_W    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] i_sample_data,
    input  logic                    i_eval,
    input  logic                    i_trig_edge,
    input  logic [SAMPLE_WIDTH-1:0] i_trig_level,
    input  logic                    i_auto_mode,
    input  logic [TIMEOUT_W-1:0]    i_auto_timeout,
    output logic                    o_trig_hit,
    output logic                    o_forced_hit
);

    logic [SAMPLE_WIDTH-1:0] r_prev;
    logic                    r_prev_valid;
    logic [TIMEOUT_W-1:0]    r_tcnt;

    logic                    w_rise;
    logic                    w_fall;
    logic                    w_edge;
    logic                    w_timeout;
    logic [TIMEOUT_W:0]      w_tcnt_nxt;

    // Previous-sample history and armed-sample counter, restarted on every arm.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_tcnt       <= '0;
        end else if (i_sample_valid) begin
            r_prev       <= i_sample_data;
            r_prev_valid <= 1'b1;
            if (i_eval) r_tcnt <= r_tcnt + TIMEOUT_W'(1);
        end
    end

    // Edge comparators and timeout match; an edge wins over a forced trigger.
    always_comb begin
        w_rise     = (r_prev < i_trig_level) && (i_sample_data >= i_trig_level);
        w_fall     = (r_prev > i_trig_level) && (i_sample_data <= i_trig_level);
        w_edge     = i_sample_valid && i_eval && r_prev_valid &&
                     ((trig_edge_e'(i_trig_edge) == EDGE_FALLING) ? w_fall : w_rise);
        w_tcnt_nxt = {1'b0, r_tcnt} + (TIMEOUT_W + 1)'(1);
        w_timeout  = i_sample_valid && i_eval && i_auto_mode &&
                     (i_auto_timeout != '0) && (w_tcnt_nxt == {1'b0, i_auto_timeout});
        o_trig_hit   = w_edge || w_timeout;
        o_forced_hit = w_timeout && !w_edge;
    end

endmodule

// File: rtl/trigger_capture_ctrl.sv
// Acquisition front-end: streams samples into the circular sample RAM, runs
// the pre-trigger / trigger / post-trigger capture FSM and publishes the
// start address of the completed capture.
module trigger_capture_ctrl
    import scope_pkg::*;
#(
    parameter int ADDR_WIDTH   = SCOPE_ADDR_WIDTH,
    parameter int SAMPLE_WIDTH = SCOPE_SAMPLE_WIDTH,
    parameter int PRETRIG      = 256,
    parameter int CAPTURE_LEN  = 4096,
    parameter int TIMEOUT_W    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_arm,
    input  logic                    i_abort,
    input  logic                    i_auto_mode,
    input  logic [TIMEOUT_W-1:0]    i_auto_timeout,
    input  logic                    i_trig_edge,
    input  logic [SAMPLE_WIDTH-1:0] i_trig_level,
    input  logic                    i_sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] i_sample_data,
    output logic                    o_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_wr_addr,
    output logic [SAMPLE_WIDTH-1:0] o_wr_data,
    output logic                    o_triggered,
    output logic                    o_forced,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [ADDR_WIDTH-1:0]   o_sample_start_address
);

    // Samples after the trigger sample needed to complete one capture.
    localparam int POST_LEN = CAPTURE_LEN - PRETRIG - 1;
    localparam int CNT_W    = $clog2(CAPTURE_LEN + 1);

    cap_state_e              r_state;
    cap_state_e              w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   r_trig_addr;

    logic                    w_busy;
    logic                    w_acc;
    logic                    w_arm_go;
    logic                    w_trig_hit;
    logic                    w_forced_hit;
    logic                    w_enter_done;
    logic [ADDR_WIDTH-1:0]   w_t_addr;

    trigger_detect #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .TIMEOUT_W    (TIMEOUT_W)
    ) u_detect (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_clear        (w_arm_go),
        .i_sample_valid (w_acc),
        .i_sample_data  (i_sample_data),
        .i_eval         (r_state == ST_ARMED),
        .i_trig_edge    (i_trig_edge),
        .i_trig_level   (i_trig_level),
        .i_auto_mode    (i_auto_mode),
        .i_auto_timeout (i_auto_timeout),
        .o_trig_hit     (w_trig_hit),
        .o_forced_hit   (w_forced_hit)
    );

    // Acceptance qualifiers and next-state; abort overrides arm and trigger.
    always_comb begin
        w_busy   = is_busy(r_state);
        w_acc    = w_busy && i_sample_valid && !i_abort;
        w_arm_go = i_arm && !i_abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        // A trigger straight into DONE has not latched T yet, so use the pointer.
        w_t_addr = (r_state == ST_ARMED) ? r_ptr : r_trig_addr;

        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_arm) w_state_nxt = (PRETRIG == 0) ? ST_ARMED : ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (w_acc && (r_cnt == CNT_W'(PRETRIG - 1))) w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_trig_hit) w_state_nxt = (POST_LEN == 0) ? ST_DONE : ST_POSTFILL;
                end
                ST_POSTFILL: begin
                    if (w_acc && (r_cnt == CNT_W'(POST_LEN - 1))) w_state_nxt = ST_DONE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        w_enter_done = (r_state != ST_DONE) && (w_state_nxt == ST_DONE);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Per-phase sample counter, restarted on every state change.
    always_ff @(posedge i_clk) begin
        if (i_reset)                     r_cnt <= '0;
        else if (r_state != w_state_nxt) r_cnt <= '0;
        else if (w_acc)                  r_cnt <= r_cnt + CNT_W'(1);
    end

    // RAM write port, circular pointer and trigger address latch.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_triggered <= 1'b0;
            r_ptr       <= '0;
            r_trig_addr <= '0;
        end else begin
            o_wr_en     <= w_acc;
            o_triggered <= w_trig_hit;
            if (w_acc) begin
                o_wr_addr <= r_ptr;
                o_wr_data <= i_sample_data;
                r_ptr     <= r_ptr + ADDR_WIDTH'(1);
            end
            if (w_trig_hit) r_trig_addr <= r_ptr;
        end
    end

    // Capture status: done / forced flags and published start address.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_done                 <= 1'b0;
            o_forced               <= 1'b0;
            o_sample_start_address <= '0;
        end else if (i_abort) begin
            o_done <= 1'b0;
        end else if (w_arm_go) begin
            o_done   <= 1'b0;
            o_forced <= 1'b0;
        end else begin
            if (w_trig_hit) o_forced <= w_forced_hit;
            if (w_enter_done) begin
                o_done                 <= 1'b1;
                o_sample_start_address <= w_t_addr - ADDR_WIDTH'(PRETRIG);
            end
        end
    end

    assign o_busy = w_busy;

endmodule
